// File: rtl/tlv5618_scheduler.sv
// ---------------------------------------------------------------------------
// tlv5618_scheduler
// Purpose: sequences a TLV5618 SPI DAC driver for two channel requesters
//   (A and B). Each channel holds one pending 12-bit code. A new request
//   before service replaces the pending code. The block builds the 16-bit
//   TLV5618 command word, issues one en_conv pulse per frame and waits for
//   conv_done. It arbitrates round-robin, or in synchronous-update pairs
//   (B to buffer, then A write).
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   req_a/b    in   1-cycle strobe, load data_a/b as the pending code
//   data_a/b   in   12-bit channel codes
//   sync_mode  in   1 = update A and B together when both are pending
//   div_parm   out  driver SCLK divider (constant DIV)
//   dac_data   out  command word, held stable while the driver is busy
//   en_conv    out  1-cycle start pulse to the driver
//   conv_done  in   1-cycle frame-complete pulse from the driver
//   done_a/b   out  1-cycle pulse, channel output updated
//   busy       out  high while not idle
//   err_to     out  sticky transfer-timeout flag, cleared by reset only
// ---------------------------------------------------------------------------
module tlv5618_scheduler #(
    parameter logic        SPD     = 1'b1,
    parameter logic [7:0]  DIV     = 8'd0,
    parameter logic [15:0] TIMEOUT = 16'd4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [11:0] data_a,
    input  logic        req_b,
    input  logic [11:0] data_b,
    input  logic        sync_mode,
    output logic [7:0]  div_parm,
    output logic [15:0] dac_data,
    output logic        en_conv,
    input  logic        conv_done,
    output logic        done_a,
    output logic        done_b,
    output logic        busy,
    output logic        err_to
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_dac_data;
    logic [11:0] r_pair_code;   // A code captured at pair start
    logic [15:0] r_cnt;
    logic [1:0]  r_job;         // [0]=A, [1]=B channels of the current job
    logic        r_pair;
    logic        r_step2;
    logic        r_last_b;      // 1 = B was served last, so A wins a tie
    logic        r_done_a;
    logic        r_done_b;
    logic        r_err;

    logic        w_sel_a;
    logic        w_sel_b;
    logic        w_sel_pair;
    logic        w_finish;
    logic        w_timeout;

    logic [1:0]  w_req;
    logic [11:0] w_data [2];
    logic [1:0]  w_pend;
    logic [11:0] w_code_eff [2];

    assign w_req     = {req_b, req_a};
    assign w_data[0] = data_a;
    assign w_data[1] = data_b;

    // Per-channel pending register. A request in the same cycle as the clear
    // wins, so a code arriving while its channel is being issued is not lost.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic        r_pend;
            logic [11:0] r_code;
            logic        w_clr;

            assign w_clr = (r_state == S_ISSUE) && !r_step2 && r_job[gi];
            // A request on the choosing edge is newer than the stored code.
            assign w_code_eff[gi] = w_req[gi] ? w_data[gi] : r_code;
            assign w_pend[gi]     = r_pend;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pend <= 1'b0;
                    r_code <= 12'd0;
                end else if (w_req[gi]) begin
                    r_pend <= 1'b1;
                    r_code <= w_data[gi];
                end else if (w_clr) begin
                    r_pend <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_a      = 1'b0;
        w_sel_b      = 1'b0;
        w_sel_pair   = 1'b0;
        w_finish     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sync_mode && w_pend[0] && w_pend[1]) begin
                    w_sel_pair = 1'b1;
                end else if (w_pend[0] && (!w_pend[1] || r_last_b)) begin
                    w_sel_a = 1'b1;
                end else if (w_pend[1]) begin
                    w_sel_b = 1'b1;
                end
                if (w_pend[0] || w_pend[1]) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done) begin
                    if (r_pair && !r_step2) begin
                        w_state_next = S_ISSUE;
                    end else begin
                        w_finish     = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end else if (r_cnt == TIMEOUT - 16'd1) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dac_data  <= 16'd0;
            r_pair_code <= 12'd0;
            r_cnt       <= 16'd0;
            r_job       <= 2'b00;
            r_pair      <= 1'b0;
            r_step2     <= 1'b0;
            r_last_b    <= 1'b1;
            r_done_a    <= 1'b0;
            r_done_b    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done_a <= w_finish && r_job[0];
            r_done_b <= w_finish && r_job[1];
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= 16'd0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_sel_pair) begin
                r_dac_data  <= {1'b0, SPD, 1'b0, 1'b1, w_code_eff[1]};
                r_pair_code <= w_code_eff[0];
                r_job       <= 2'b11;
                r_pair      <= 1'b1;
                r_step2     <= 1'b0;
                r_last_b    <= 1'b0;   // the A write finishes the pair
            end else if (w_sel_a) begin
                r_dac_data <= {1'b1, SPD, 1'b0, 1'b0, w_code_eff[0]};
                r_job      <= 2'b01;
                r_pair     <= 1'b0;
                r_step2    <= 1'b0;
                r_last_b   <= 1'b0;
            end else if (w_sel_b) begin
                r_dac_data <= {1'b0, SPD, 1'b0, 1'b0, w_code_eff[1]};
                r_job      <= 2'b10;
                r_pair     <= 1'b0;
                r_step2    <= 1'b0;
                r_last_b   <= 1'b1;
            end else if (r_state == S_WAIT && w_state_next == S_ISSUE) begin
                // Second step of a pair: A write latches both DAC outputs.
                r_dac_data <= {1'b1, SPD, 1'b0, 1'b0, r_pair_code};
                r_step2    <= 1'b1;
            end
        end
    end

    assign div_parm = DIV;
    assign dac_data = r_dac_data;
    assign en_conv  = (r_state == S_ISSUE);
    assign busy     = (r_state != S_IDLE);
    assign done_a   = r_done_a;
    assign done_b   = r_done_b;
    assign err_to   = r_err;

endmodule
